// File: rtl/icache_nway.sv
// N-way set-associative read-only icache: tree PLRU, wrapped critical-word-first fill, fence.i flush sweep.
// Ports: clk, rst_n, addr/rd_en/rdata/ready (fetch), flush/flush_busy, mem_* (fill), perf_* when ICACHE_PERF_EN.
module icache_nway #(
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        flush,
  output logic        flush_busy,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int SET_W    = $clog2(SETS);
  localparam int TAG_W    = 32 - SET_W - OFFSET_W;
  localparam int WORDS    = LINE_BYTES / 4;
  localparam int WORD_W   = OFFSET_W - 2;
  localparam int LW       = $clog2(WAYS);
  localparam int WAY_W    = (WAYS > 1) ? LW : 1;
  localparam int PW       = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [PW-1:0]    plru_q  [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS][WORDS];

  logic [TAG_W-1:0]  f_tag;
  logic [SET_W-1:0]  f_set;
  logic [WORD_W-1:0] f_word;
  logic [WAY_W-1:0]  f_way;
  logic [WORD_W-1:0] cnt;
  logic [31:0]       crit_q;
  logic [SET_W-1:0]  fcnt;
  logic              pend_q;

  logic [TAG_W-1:0]  a_tag;
  logic [SET_W-1:0]  a_set;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] widx;
  logic              unused_addr;

  assign a_tag       = addr[31:SET_W+OFFSET_W];
  assign a_set       = addr[SET_W+OFFSET_W-1:OFFSET_W];
  assign a_word      = addr[OFFSET_W-1:2];
  assign unused_addr = ^addr[1:0];
  assign widx        = f_word + cnt;

  // Tree bits: node n has children 2n+1 / 2n+2; bit=1 sends the victim right.
  function automatic logic [PW-1:0] plru_touch(
    input logic [PW-1:0]    p,
    input logic [WAY_W-1:0] w
  );
    logic [PW-1:0] r;
    logic          dir;
    int            n;
    r = p;
    n = 0;
    for (int d = 0; d < LW; d++) begin
      dir  = w[LW-1-d];
      r[n] = ~dir;
      n    = 2 * n + 1 + int'(dir);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(
    input logic [PW-1:0] p
  );
    logic [WAY_W-1:0] v;
    logic             dir;
    int               n;
    v = '0;
    n = 0;
    for (int d = 0; d < LW; d++) begin
      dir         = p[n];
      v[LW-1-d]   = dir;
      n           = 2 * n + 1 + int'(dir);
    end
    return v;
  endfunction

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             any_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[a_set][w] && tag_q[a_set][w] == a_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[a_set][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim = any_inv ? inv_way : plru_victim(plru_q[a_set]);
  end

  logic idle_req;
  logic hit_go;
  logic miss_go;
  logic beat;
  logic last;
  logic sweep_end;

  assign idle_req  = state_q == S_IDLE && !pend_q && rd_en;
  assign hit_go    = idle_req && hit;
  assign miss_go   = idle_req && !hit;
  assign beat      = state_q == S_FILL && mem_valid;
  assign last      = beat && cnt == WORD_W'(WORDS - 1);
  assign sweep_end = state_q == S_FLUSH && fcnt == SET_W'(SETS - 1);

  assign flush_busy = pend_q || state_q == S_FLUSH;

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    rdata    = '0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_FLUSH;
        end else if (rd_en) begin
          if (hit) begin
            ready = 1'b1;
            rdata = data_q[a_set][hit_way][a_word];
          end else begin
            state_d = S_FILL;
          end
        end else begin
          ready = 1'b1;
        end
      end
      S_FILL: begin
        mem_rd   = 1'b1;
        mem_addr = {f_tag, f_set, widx, 2'b00};
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        ready   = 1'b1;
        rdata   = crit_q;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (sweep_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      f_tag   <= '0;
      f_set   <= '0;
      f_word  <= '0;
      f_way   <= '0;
      cnt     <= '0;
      crit_q  <= '0;
      fcnt    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (flush) pend_q <= 1'b1;
      if (miss_go) begin
        f_tag  <= a_tag;
        f_set  <= a_set;
        f_word <= a_word;
        f_way  <= victim;
        cnt    <= '0;
      end
      if (hit_go) plru_q[a_set] <= plru_touch(plru_q[a_set], hit_way);
      if (beat) begin
        cnt <= cnt + 1'b1;
        if (cnt == '0) crit_q <= mem_rdata;
      end
      if (last) begin
        valid_q[f_set][f_way] <= 1'b1;
        plru_q[f_set]         <= plru_touch(plru_q[f_set], f_way);
      end
      if (state_q == S_FLUSH) begin
        valid_q[fcnt] <= '0;
        plru_q[fcnt]  <= '0;
        fcnt          <= fcnt + 1'b1;
        // A pulse landing in the final sweep cycle is absorbed.
        if (sweep_end) pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) data_q[f_set][f_way][widx] <= mem_rdata;
    if (last) tag_q[f_set][f_way] <= f_tag;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit_go && perf_hits != '1) perf_hits <= perf_hits + 1'b1;
      if (miss_go && perf_misses != '1) perf_misses <= perf_misses + 1'b1;
    end
  end
`endif

endmodule
